// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited imem requests, and an
// in-order instruction buffer towards decode with redirect flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {BOOT, RUN} state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q;
  logic [CNT_W-1:0]   out_q;
  logic [CNT_W-1:0]   disc_q;
  logic [CNT_W-1:0]   cnt_p1;
  logic [PTR_W-1:0]   wr_p1, rd_p1;
  logic [PTR_W-1:0]   tag_wr_p0, tag_rd_p0;

  logic [31:0]        tag_pc_p0  [FIFO_DEPTH];
  logic [31:0]        fifo_pc_p1 [FIFO_DEPTH];
  logic [31:0]        fifo_ins_p1[FIFO_DEPTH];

  logic               issue, rsp, push, pop, credit;
  logic [CNT_W:0]     inflight;
  logic [31:0]        target_pc;

  assign inflight  = {1'b0, cnt_p1} + {1'b0, out_q};
  assign credit    = inflight < (CNT_W+1)'(FIFO_DEPTH);
  assign target_pc = redirect_pc_i & 32'hFFFF_FFFC;

  assign imem_req_o    = (state_q == RUN) && credit && !redirect_i;
  assign imem_addr_o   = pc_q;
  assign issue         = imem_req_o && imem_gnt_i;
  // A response with nothing outstanding (e.g. left over from before a reset) is ignored.
  assign rsp           = imem_rvalid_i && (out_q != '0);
  assign push          = rsp && (disc_q == '0) && !redirect_i;
  assign instr_valid_o = (cnt_p1 != '0);
  assign pop           = instr_valid_o && instr_ready_i;
  assign instr_o       = instr_valid_o ? fifo_ins_p1[rd_p1] : '0;
  assign pc_o          = instr_valid_o ? fifo_pc_p1[rd_p1]  : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= BOOT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Request stage (p0): PC, outstanding/discard accounting, PC tag queue
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q      <= RESET_PC;
      out_q     <= '0;
      disc_q    <= '0;
      tag_wr_p0 <= '0;
      tag_rd_p0 <= '0;
    end else begin
      out_q     <= out_q + CNT_W'(issue) - CNT_W'(rsp);
      tag_wr_p0 <= tag_wr_p0 + PTR_W'(issue);
      tag_rd_p0 <= tag_rd_p0 + PTR_W'(rsp);
      if (redirect_i) begin
        pc_q   <= target_pc;
        disc_q <= out_q - CNT_W'(rsp);
      end else begin
        if (issue) pc_q <= pc_q + 32'd4;
        if (rsp && disc_q != '0) disc_q <= disc_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (issue) tag_pc_p0[tag_wr_p0] <= pc_q;
  end

  // Buffer stage (p1): instruction FIFO towards decode
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_p1 <= '0;
      wr_p1  <= '0;
      rd_p1  <= '0;
    end else if (redirect_i) begin
      cnt_p1 <= '0;
      wr_p1  <= '0;
      rd_p1  <= '0;
    end else begin
      cnt_p1 <= cnt_p1 + CNT_W'(push) - CNT_W'(pop);
      wr_p1  <= wr_p1 + PTR_W'(push);
      rd_p1  <= rd_p1 + PTR_W'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_pc_p1[wr_p1]  <= tag_pc_p0[tag_rd_p0];
      fifo_ins_p1[wr_p1] <= imem_rdata_i;
    end
  end

`ifndef SYNTHESIS
  rvalid_needs_request: assert property (@(posedge clk_i) disable iff (rst_i)
    !(imem_rvalid_i && state_q == RUN && out_q == '0));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a small in-order memory model answers grants,
// and every expected {pc, instr} is queued at grant time and checked at handoff.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, pc;
  logic        rsp_en;

  logic        req2, valid2;
  logic [31:0] addr2, instr2, pc2;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] gnt_log[$];
  logic [31:0] pop_log[$];
  logic [31:0] u2_log[$];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .instr_o(instr), .pc_o(pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_wrap (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_gnt_i(1'b1),
    .imem_rvalid_i(1'b0), .imem_rdata_i(32'h0),
    .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .instr_valid_o(valid2), .instr_ready_i(1'b1),
    .instr_o(instr2), .pc_o(pc2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at the falling edge: records the handshakes of the coming rising edge.
  task automatic sample();
    logic [31:0] e;
    if (rst) begin
      exp_q.delete();
      mem_q.delete();
      u2_log.delete();
      return;
    end
    if (instr_valid && instr_ready) begin
      pop_log.push_back(pc);
      if (exp_q.size() == 0) begin
        check("spurious_valid", {31'b0, instr_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", pc, e);
        check("sb_instr", instr, ~e);
      end
    end
    if (redirect) begin
      check("req_in_redirect", {31'b0, imem_req}, 32'd0);
      exp_q.delete();
    end else if (imem_req && imem_gnt) begin
      exp_q.push_back(imem_addr);
      mem_q.push_back(imem_addr);
      gnt_log.push_back(imem_addr);
    end
    if (req2) u2_log.push_back(addr2);
  endtask

  task automatic respond();
    if (rsp_en && mem_q.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = ~mem_q.pop_front();
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    respond();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    pop_log.delete();
    gnt_log.delete();
    rst = 1'b0;
  endtask

  task automatic wait_pop(input string tag, input logic [31:0] want);
    int n0;
    int k;
    n0 = pop_log.size();
    k  = 0;
    while (pop_log.size() == n0 && k < 60) begin
      tick();
      k++;
    end
    check({tag, "_arrived"}, 32'(pop_log.size()), 32'(n0 + 1));
    if (pop_log.size() > n0) check(tag, pop_log[n0], want);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; imem_gnt = 1'b0; rsp_en = 1'b1; instr_ready = 1'b1;
    redirect = 1'b0; redirect_pc = 32'h0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    tick();
    tick();
    check("rst_req",   {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc",    pc, 32'h0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_addr_wrapdut", addr2, 32'hFFFF_FFFC);

    // streaming fetch after reset
    imem_gnt = 1'b1;
    rst = 1'b0;
    n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    check("t1_latency", 32'(n), 32'd3);
    check("t1_first_pc", pc, 32'h0);
    repeat (12) tick();
    for (int i = 0; i < 4; i++) begin
      check("t1_addr_seq", gnt_log[i], 32'(4 * i));
      check("t1_pop_seq", pop_log[i], 32'(4 * i));
    end
    check("t5_wrap_count", 32'(u2_log.size()), 32'd2);
    check("t5_wrap_addr0", u2_log[0], 32'hFFFF_FFFC);
    check("t5_wrap_addr1", u2_log[1], 32'h0000_0000);

    // decode stalled: credit limits to FIFO_DEPTH grants
    instr_ready = 1'b0;
    do_reset();
    repeat (10) tick();
    check("t2_grants", 32'(gnt_log.size()), 32'd2);
    check("t2_req_off", {31'b0, imem_req}, 32'd0);
    check("t2_valid", {31'b0, instr_valid}, 32'd1);
    check("t2_head_pc", pc, 32'h0);
    tick();
    check("t2_head_stable", pc, 32'h0);
    check("t2_head_instr", instr, 32'hFFFF_FFFF);
    instr_ready = 1'b1;
    tick();
    check("t2_resume", {31'b0, imem_req}, 32'd1);
    repeat (10) tick();
    for (int i = 0; i < 3; i++) check("t2_order", pop_log[i], 32'(4 * i));

    // redirect with two requests in flight
    rsp_en = 1'b0;
    do_reset();
    repeat (6) tick();
    imem_gnt = 1'b0;
    rsp_en = 1'b1;
    repeat (6) tick();
    imem_gnt = 1'b1;
    rsp_en = 1'b0;
    repeat (6) tick();
    check("t3_inflight_n", 32'(gnt_log.size()), 32'd4);
    check("t3_inflight_a", gnt_log[2], 32'h8);
    check("t3_inflight_b", gnt_log[3], 32'hC);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    rsp_en = 1'b1;
    wait_pop("t3_target_pc", 32'h100);
    check("t3_target_addr", gnt_log[4], 32'h100);

    // redirect coinciding with rvalid and gnt, then back-to-back redirect
    repeat (5) tick();
    n = 0;
    while (!(imem_rvalid && imem_req) && n < 20) begin
      tick();
      n++;
    end
    check("t4_setup_req", {31'b0, imem_req}, 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0300;
    tick();
    redirect_pc = 32'h0000_0206;
    tick();
    redirect = 1'b0;
    wait_pop("t4_target_pc", 32'h204);
    repeat (10) tick();

    // reset with a full buffer; stale rvalid right after release
    instr_ready = 1'b0;
    do_reset();
    repeat (8) tick();
    check("t6_full", {31'b0, instr_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", {31'b0, instr_valid}, 32'd0);
    check("t6_rst_req", {31'b0, imem_req}, 32'd0);
    check("t6_rst_pc", pc, 32'h0);
    check("t6_rst_instr", instr, 32'h0);
    check("t6_rst_addr", imem_addr, 32'h0);
    tick();
    gnt_log.delete();
    pop_log.delete();
    instr_ready = 1'b1;
    imem_gnt = 1'b0;
    rst = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    check("t6_late_ignored", {31'b0, instr_valid}, 32'd0);
    tick();
    check("t6_still_empty", {31'b0, instr_valid}, 32'd0);
    imem_gnt = 1'b1;
    wait_pop("t6_restart_pc", 32'h0);
    check("t6_restart_addr", gnt_log[0], 32'h0);
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
